// File: rtl/stage_fifo.sv
// -----------------------------------------------------------------------------
// stage_fifo
//
// Elastic pipeline stage placed between datapath units (fetch->decode,
// decode->execute, ...). Holds up to DEPTH payloads of WIDTH bits in a
// circular buffer and moves them with valid/ready handshakes on both sides.
// A downstream `busy` stalls the output. `flush` empties the stage for
// branch/trap redirects.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; drops all entries
//   flush      in   discard stored entries and the current input
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts an entry this cycle (state/reset/flush only)
//   in_data    in   upstream payload, WIDTH bits
//   out_valid  out  out_data is a valid entry offered downstream
//   out_ready  in   downstream accepts this cycle
//   out_data   out  head-of-buffer payload (holds when out_valid is low)
//   busy       in   downstream occupied; suppresses out_valid
//   count      out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Pointer arithmetic relies on natural wrap of a PW-bit counter.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("stage_fifo: DEPTH must be a power of two and >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             blocked;
    logic             push;
    logic             pop;

    // Reset and flush gate both handshakes combinationally so nothing is
    // accepted on a cycle whose state is about to be discarded.
    assign blocked   = reset | flush;

    // in_ready depends on the stored count only: a pop while full does not
    // open a slot until the next cycle, keeping out_ready off this path.
    assign in_ready  = !blocked && (count_q != FULL);
    assign out_valid = !blocked && (count_q != '0) && !busy;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // No bypass: the head is always read from storage.
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // push is impossible when full and pop impossible when empty,
        // so count stays within 0..DEPTH by construction.
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; a flushed entry is simply orphaned.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) count_q <= FULL);
    a_no_underflow: assert property (@(posedge clk) !(pop && count_q == '0));
    a_no_overflow: assert property (@(posedge clk) !(push && count_q == FULL));
`endif

endmodule

// File: tb/tb_stage_fifo.sv
// -----------------------------------------------------------------------------
// tb_stage_fifo
//
// Drives two stage_fifo instances: a DEPTH=2 stage for the directed scenarios
// and a DEPTH=4 stage for a randomized wrap-around run. Each stage has a
// queue-based reference model that tracks occupancy and order from the
// handshake rules.
// -----------------------------------------------------------------------------
module tb_stage_fifo;

    logic        clk;
    logic        reset;

    // DEPTH = 2 instance
    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  count2;

    // DEPTH = 4 instance
    logic        flush4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [31:0] in_data4, out_data4;
    logic [2:0]  count4;

    int checks;
    int failures;

    logic [31:0] m2[$];
    logic [31:0] m4[$];
    logic [31:0] got2[$];
    logic [31:0] got4[$];

    stage_fifo #(.WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .count(count2)
    );

    stage_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .busy(busy4), .count(count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle on the DEPTH=2 stage. Called at the falling edge
    // after checks; returns just after the next rising edge.
    task automatic tick2();
        logic        push;
        logic        pop;
        logic [31:0] d;
        push = in_valid2 && !reset && !flush2 && (m2.size() != 2);
        pop  = out_ready2 && !reset && !flush2 && (m2.size() != 0) && !busy2;
        d    = in_data2;
        if (out_valid2 && out_ready2) got2.push_back(out_data2);
        @(posedge clk);
        if (reset || flush2) begin
            m2.delete();
        end else begin
            if (pop) void'(m2.pop_front());
            if (push) m2.push_back(d);
        end
        if (reset) m4.delete();
        #1;
    endtask

    task automatic tick4();
        logic        push;
        logic        pop;
        logic [31:0] d;
        push = in_valid4 && !reset && !flush4 && (m4.size() != 4);
        pop  = out_ready4 && !reset && !flush4 && (m4.size() != 0) && !busy4;
        d    = in_data4;
        if (out_valid4 && out_ready4) got4.push_back(out_data4);
        @(posedge clk);
        if (reset || flush4) begin
            m4.delete();
        end else begin
            if (pop) void'(m4.pop_front());
            if (push) m4.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 32'hAA;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_ready cyc=%0d got=%b want=0", i, in_ready2);
            end
            checks++;
            if (out_valid2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid cyc=%0d got=%b want=0", i, out_valid2);
            end
            tick2();
        end
        reset     = 1'b0;
        in_valid2 = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got=%b want=1", in_ready2);
        end
        checks++;
        if (count2 !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_count got=%0d want=0", count2);
        end
        checks++;
        if (out_valid2 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_out_valid got=%b want=0", out_valid2);
        end
        checks++;
        if (in_ready4 !== 1'b1 || count4 !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_d4 got in_ready=%b count=%0d want 1/0", in_ready4, count4);
        end
        tick2();
    endtask

    task automatic test_streaming();
        got2.delete();
        out_ready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid2 = (i < 4);
            in_data2  = 32'(i + 1);
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                checks++;
                if (out_valid2 !== 1'b1 || out_data2 !== 32'(i)) begin
                    failures++;
                    $display("FAIL stream_out cyc=%0d got valid=%b data=%h want 1/%h",
                             i, out_valid2, out_data2, 32'(i));
                end
                checks++;
                if (count2 !== 2'd1) begin
                    failures++;
                    $display("FAIL stream_count cyc=%0d got=%0d want=1", i, count2);
                end
            end
            checks++;
            if (in_ready2 !== (m2.size() != 2)) begin
                failures++;
                $display("FAIL stream_in_ready cyc=%0d got=%b", i, in_ready2);
            end
            tick2();
        end
        checks++;
        if (got2.size() != 4 || got2[0] !== 32'h1 || got2[3] !== 32'h4) begin
            failures++;
            $display("FAIL stream_order got size=%0d want 4 in order", got2.size());
        end
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
    endtask

    task automatic test_fill_full();
        logic [31:0] exp[$];
        got2.delete();
        exp = '{32'h10, 32'h11, 32'h12};
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'h10;
        @(negedge clk); tick2();
        in_data2 = 32'h11;
        @(negedge clk); tick2();
        in_data2 = 32'h12;
        @(negedge clk);
        checks++;
        if (count2 !== 2'd2 || in_ready2 !== 1'b0) begin
            failures++;
            $display("FAIL fill_full got count=%0d in_ready=%b want 2/0", count2, in_ready2);
        end
        tick2();
        out_ready2 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b0 || out_valid2 !== 1'b1 || out_data2 !== 32'h10) begin
            failures++;
            $display("FAIL full_pop_no_pass got in_ready=%b valid=%b data=%h want 0/1/10",
                     in_ready2, out_valid2, out_data2);
        end
        tick2();
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b1 || count2 !== 2'd1) begin
            failures++;
            $display("FAIL after_pop_ready got in_ready=%b count=%0d want 1/1", in_ready2, count2);
        end
        tick2();
        in_valid2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick2();
        end
        checks++;
        if (got2 != exp) begin
            failures++;
            $display("FAIL fill_order got size=%0d first=%h want 10,11,12", got2.size(),
                     (got2.size() > 0) ? got2[0] : 32'h0);
        end
        checks++;
        if (count2 !== 2'd0) begin
            failures++;
            $display("FAIL fill_drained_count got=%0d want=0", count2);
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_busy();
        logic [31:0] exp[$];
        got2.delete();
        exp = '{32'h20, 32'h21};
        in_valid2 = 1'b1;
        in_data2  = 32'h20;
        @(negedge clk); tick2();
        busy2      = 1'b1;
        out_ready2 = 1'b1;
        in_data2   = 32'h21;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid2 !== 1'b0 || out_data2 !== 32'h20) begin
                failures++;
                $display("FAIL busy_hold cyc=%0d got valid=%b data=%h want 0/20",
                         i, out_valid2, out_data2);
            end
            if (i == 0) begin
                checks++;
                if (in_ready2 !== 1'b1) begin
                    failures++;
                    $display("FAIL busy_push_ready got=%b want=1", in_ready2);
                end
            end
            tick2();
            in_valid2 = 1'b0;
        end
        busy2 = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b1 || count2 !== 2'd2) begin
            failures++;
            $display("FAIL busy_release got valid=%b count=%0d want 1/2", out_valid2, count2);
        end
        tick2();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tick2();
        end
        checks++;
        if (got2 != exp) begin
            failures++;
            $display("FAIL busy_order got size=%0d want 20,21", got2.size());
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_flush();
        got2.delete();
        out_ready2 = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = 32'h2A;
        @(negedge clk); tick2();
        in_data2 = 32'h2B;
        @(negedge clk); tick2();
        flush2     = 1'b1;
        in_data2   = 32'h30;
        out_ready2 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready2 !== 1'b0 || out_valid2 !== 1'b0) begin
            failures++;
            $display("FAIL flush_gate got in_ready=%b valid=%b want 0/0", in_ready2, out_valid2);
        end
        tick2();
        flush2    = 1'b0;
        in_valid2 = 1'b1;
        in_data2  = 32'h31;
        @(negedge clk);
        checks++;
        if (count2 !== 2'd0 || out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL flush_after got count=%0d valid=%b in_ready=%b want 0/0/1",
                     count2, out_valid2, in_ready2);
        end
        tick2();
        in_valid2 = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid2 !== 1'b1 || out_data2 !== 32'h31) begin
            failures++;
            $display("FAIL flush_next got valid=%b data=%h want 1/31", out_valid2, out_data2);
        end
        tick2();
        checks++;
        if (got2.size() != 1 || got2[0] !== 32'h31) begin
            failures++;
            $display("FAIL flush_order got size=%0d want only 31", got2.size());
        end
        out_ready2 = 1'b0;
    endtask

    task automatic test_wrap_depth4();
        logic [31:0] sent[$];
        int          n_acc;
        int          cyc;
        got4.delete();
        n_acc = 0;
        cyc   = 0;
        while ((n_acc < 10 || m4.size() != 0) && cyc < 400) begin
            if (!in_valid4 && n_acc < 10 && $urandom_range(0, 3) != 0) begin
                in_valid4 = 1'b1;
                in_data4  = $urandom;
            end
            out_ready4 = ($urandom_range(0, 2) != 0);
            busy4      = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (count4 !== 3'(m4.size()) || count4 > 3'd4) begin
                failures++;
                $display("FAIL wrap_count cyc=%0d got=%0d want=%0d", cyc, count4, m4.size());
            end
            checks++;
            if (in_ready4 !== (m4.size() != 4) ||
                out_valid4 !== (m4.size() != 0 && !busy4)) begin
                failures++;
                $display("FAIL wrap_handshake cyc=%0d got in_ready=%b valid=%b", cyc,
                         in_ready4, out_valid4);
            end
            if (m4.size() != 0) begin
                checks++;
                if (out_data4 !== m4[0]) begin
                    failures++;
                    $display("FAIL wrap_head cyc=%0d got=%h want=%h", cyc, out_data4, m4[0]);
                end
            end
            if (in_valid4 && m4.size() != 4) begin
                sent.push_back(in_data4);
                n_acc++;
                tick4();
                in_valid4 = 1'b0;
            end else begin
                tick4();
            end
            cyc++;
        end
        checks++;
        if (cyc >= 400) begin
            failures++;
            $display("FAIL wrap_timeout accepted=%0d pending=%0d want 10/0", n_acc, m4.size());
        end
        checks++;
        if (got4 != sent) begin
            failures++;
            $display("FAIL wrap_order got size=%0d want size=%0d in order", got4.size(), sent.size());
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        busy4      = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        flush2     = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        out_ready2 = 1'b0;
        busy2      = 1'b0;
        flush4     = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 1'b0;
        busy4      = 1'b0;

        test_reset();
        test_streaming();
        test_fill_full();
        test_busy();
        test_flush();
        test_wrap_depth4();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
